multicycle_datapath: RTL and testbench
======================================

MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width (instruction width fixed at 32).
REQ-002 SHALL have parameter REG_NUM, default 32, register count (power of 2, ≤32; register address width is $clog2(REG_NUM)).
REQ-003 SHALL have parameter RESET_PC, default 0, PC value after reset.
REQ-004 iClk  in  1  single clock, rising edge.
REQ-005 iRst_n  in  1  reset, asynchronous, active-low.
REQ-006 oInst_Req  out  1  instruction fetch request.
REQ-007 oInst_Addr  out  XLEN  fetch address (PC).
REQ-008 iInst_Vld  in  1  iInst_Code valid; completes the fetch.
REQ-009 iInst_Code  in  32  instruction word.
REQ-010 oData_Req  out  1  data access request.
REQ-011 oData_We  out  1  1 = store, 0 = load.
REQ-012 oData_Addr / oData_WrData  out  XLEN each  access address / store data.
REQ-013 iData_Ack  in  1  data access complete.
REQ-014 iData_RdData  in  XLEN  load data, valid with iData_Ack.
REQ-015 iDbg_RegAddr  in  5  debug read address; oDbg_RegData  out  XLEN  combinational register read (x0 and out-of-range return 0).
REQ-016 oIllegal  out  1  sticky illegal-instruction flag.

Function
REQ-017 SHALL implement FSM states FETCH, DECODE, EXECUTE, MEM, WB, TRAP.
REQ-018 FETCH: oInst_Req=1 and oInst_Addr=PC held stable until iInst_Vld is sampled 1; iInst_Code is latched into IR on that edge; next state is DECODE.
REQ-019 DECODE: rs1/rs2 are latched into A/B and the sign-extended immediate (I, S formats) is latched; next state is EXECUTE; an unsupported opcode goes to TRAP or FETCH per REQ-031.
REQ-020 Supported: R-type (0110011), I-ALU (0010011, incl. SLLI/SRLI/SRAI shamt imm[4:0], bit30 selects SRA), LW (0000011, f3=010), SW (0100011, f3=010); the ALU ops are ADD, SUB, SLL, SRL, SRA, SLT, SLTU, XOR, OR, AND, decoded from funct3/funct7[5].
REQ-021 EXECUTE: the ALU result is latched; R/I-ALU go to WB, LW/SW go to MEM.
REQ-022 MEM: oData_Req=1 with oData_Addr, oData_We and oData_WrData held stable until iData_Ack is sampled 1; LW latches iData_RdData and goes to WB; SW goes to FETCH with PC+4.
REQ-023 WB: rd is written (ALU result or load data) unless rd==0; PC becomes PC+4; next state is FETCH.
REQ-024 Zero-wait latency SHALL be R/I-ALU 4 cycles, SW 4 cycles, LW 5 cycles; each wait cycle on iInst_Vld or iData_Ack adds exactly one cycle.
REQ-025 x0 SHALL always read 0; PC arithmetic SHALL wrap modulo 2^XLEN.
REQ-026 oInst_Req and oData_Req SHALL never be high in the same cycle.
REQ-027 An rs/rd index ≥ REG_NUM SHALL read 0, and writes to it SHALL be ignored.

Reset
REQ-028 iRst_n low SHALL immediately force: state=FETCH, PC=RESET_PC, IR=0, oData_Req=0, oData_We=0, oIllegal=0, and registers x1..x(REG_NUM-1)=0.
REQ-029 Reset asserted during MEM or any wait SHALL abandon the access with no register write.
REQ-030 The first oInst_Req SHALL assert in the first cycle after iRst_n deasserts.

Configuration
REQ-031 Macro MC_DP_TRAP_EN: defined → an illegal opcode/funct3 enters TRAP, sets oIllegal=1, and holds with no further requests until reset; undefined → it executes as a NOP (PC+4, no write), TRAP is unreachable, and oIllegal is tied 0.

Structure
REQ-032 Package rv32i_pkg SHALL hold the opcode constants, the ALU-op enum typedef, and the FSM state enum typedef.
REQ-033 Sub-module mc_alu (parameter XLEN) SHALL hold the ALU; all other logic SHALL reside in multicycle_datapath.

Verification
REQ-034 ADDI x1,x0,5 (0x00500093) then ADD x2,x1,x1 (0x00108133), zero-wait -> x2=10 via debug port; each instruction takes 4 cycles; second fetch at PC=4.
REQ-035 SW x2,8(x0) (0x00202423), iData_Ack delayed 3 cycles -> oData_Req=1, Addr=8, WrData=10, We=1, all stable across the wait; next fetch at PC=12.
REQ-036 LW x3,8(x0) (0x00802183), iData_RdData=0xDEADBEEF -> x3=0xDEADBEEF after 5 cycles.
REQ-037 ADDI x0,x0,7 (0x00700013) -> x0 reads 0.
REQ-038 Reset asserted mid-MEM -> oData_Req=0 without waiting for a clock; PC=RESET_PC; registers=0.
REQ-039 0xFFFFFFFF fetched -> with MC_DP_TRAP_EN: oIllegal=1 and oInst_Req stays 0; without: next fetch at PC+4, no register change.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - opcode constants, ALU-op and FSM state types for multicycle_datapath
package rv32i_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [2:0] F3_WORD  = 3'b010;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXECUTE, MEM, WB, TRAP
  } state_e;

  // funct7[5] only distinguishes SUB for register ops; for shifts it picks SRA in both formats
  function automatic alu_op_e alu_decode(input logic is_reg, input logic [2:0] funct3,
                                         input logic f7b5);
    case (funct3)
      3'b000:  return (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu.sv
// rtl/mc_alu.sv - combinational ALU for multicycle_datapath
module mc_alu
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_e         op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] y_o
);

  localparam int SW = $clog2(XLEN);

  logic [SW-1:0] shamt;
  assign shamt = b_i[SW-1:0];

  always_comb begin
    y_o = '0;
    unique case (op_i)
      ALU_ADD:  y_o = a_i + b_i;
      ALU_SUB:  y_o = a_i - b_i;
      ALU_SLL:  y_o = a_i << shamt;
      ALU_SLT:  y_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: y_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      ALU_XOR:  y_o = a_i ^ b_i;
      ALU_SRL:  y_o = a_i >> shamt;
      ALU_SRA:  y_o = $unsigned($signed(a_i) >>> shamt);
      ALU_OR:   y_o = a_i | b_i;
      ALU_AND:  y_o = a_i & b_i;
      default:  y_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_datapath.sv
// rtl/multicycle_datapath.sv - multicycle RV32I subset (R/I-ALU, LW, SW); MC_DP_TRAP_EN traps illegal ops
module multicycle_datapath
  import rv32i_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              REG_NUM  = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            iClk,
  input  logic            iRst_n,
  output logic            oInst_Req,
  output logic [XLEN-1:0] oInst_Addr,
  input  logic            iInst_Vld,
  input  logic [31:0]     iInst_Code,
  output logic            oData_Req,
  output logic            oData_We,
  output logic [XLEN-1:0] oData_Addr,
  output logic [XLEN-1:0] oData_WrData,
  input  logic            iData_Ack,
  input  logic [XLEN-1:0] iData_RdData,
  input  logic [4:0]      iDbg_RegAddr,
  output logic [XLEN-1:0] oDbg_RegData,
  output logic            oIllegal
);

`ifdef MC_DP_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif
  localparam int              AW      = $clog2(REG_NUM);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [XLEN-1:0] alu_q, alu_d, mdr_q, mdr_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] regs_q [REG_NUM];

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd, rs1, rs2;
  logic            is_r, is_i, is_load, is_store, legal;
  logic [XLEN-1:0] imm_i, imm_s, alu_b, alu_y, wb_data;
  alu_op_e         alu_op;

  assign opcode   = ir_q[6:0];
  assign funct3   = ir_q[14:12];
  assign rd       = ir_q[11:7];
  assign rs1      = ir_q[19:15];
  assign rs2      = ir_q[24:20];
  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_IMM);
  assign is_load  = (opcode == OP_LOAD) && (funct3 == F3_WORD);
  assign is_store = (opcode == OP_STORE) && (funct3 == F3_WORD);
  assign legal    = is_r || is_i || is_load || is_store;
  assign imm_i    = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
  assign imm_s    = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign alu_op   = (is_load || is_store) ? ALU_ADD : alu_decode(is_r, funct3, ir_q[30]);
  assign alu_b    = is_r ? b_q : imm_q;
  assign wb_data  = is_load ? mdr_q : alu_q;

  mc_alu #(.XLEN(XLEN)) u_alu (
    .op_i (alu_op),
    .a_i  (a_q),
    .b_i  (alu_b),
    .y_o  (alu_y)
  );

  // x0 and indices beyond the implemented file read as zero
  function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
    if (idx == 5'd0 || int'(idx) >= REG_NUM) return '0;
    return regs_q[idx[AW-1:0]];
  endfunction

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state_q <= FETCH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   if (iInst_Vld) state_d = DECODE;
      DECODE:  state_d = !legal ? (TrapEn ? TRAP : FETCH) : EXECUTE;
      EXECUTE: state_d = (is_load || is_store) ? MEM : WB;
      MEM:     if (iData_Ack) state_d = is_load ? WB : FETCH;
      WB:      state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    oInst_Req    = iRst_n && (state_q == FETCH);
    oInst_Addr   = pc_q;
    oData_Req    = (state_q == MEM);
    oData_We     = (state_q == MEM) && is_store;
    oData_Addr   = alu_q;
    oData_WrData = b_q;
    oIllegal     = TrapEn && (state_q == TRAP);
    oDbg_RegData = rf_read(iDbg_RegAddr);
  end

  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    a_d   = a_q;
    b_d   = b_q;
    imm_d = imm_q;
    alu_d = alu_q;
    mdr_d = mdr_q;
    unique case (state_q)
      FETCH:   if (iInst_Vld) ir_d = iInst_Code;
      DECODE: begin
        a_d   = rf_read(rs1);
        b_d   = rf_read(rs2);
        imm_d = is_store ? imm_s : imm_i;
        if (!legal && !TrapEn) pc_d = pc_q + PC_STEP;
      end
      EXECUTE: alu_d = alu_y;
      MEM: begin
        if (iData_Ack) begin
          if (is_load) mdr_d = iData_RdData;
          else         pc_d  = pc_q + PC_STEP;
        end
      end
      WB:      pc_d = pc_q + PC_STEP;
      default: ;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      imm_q <= '0;
      alu_q <= '0;
      mdr_q <= '0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      a_q   <= a_d;
      b_q   <= b_d;
      imm_q <= imm_d;
      alu_q <= alu_d;
      mdr_q <= mdr_d;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
    end else if (state_q == WB && rd != 5'd0 && int'(rd) < REG_NUM) begin
      regs_q[rd[AW-1:0]] <= wb_data;
    end
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// tb/tb_multicycle_datapath.sv - randomized self-checking bench for multicycle_datapath; honours MC_DP_TRAP_EN
module tb_multicycle_datapath;

  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef MC_DP_TRAP_EN
  localparam bit TRAP_BUILD = 1'b1;
`else
  localparam bit TRAP_BUILD = 1'b0;
`endif

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b0;
  logic        oInst_Req, iInst_Vld, oData_Req, oData_We, iData_Ack, oIllegal;
  logic [31:0] oInst_Addr, iInst_Code, oData_Addr, oData_WrData, iData_RdData, oDbg_RegData;
  logic [4:0]  iDbg_RegAddr;

  multicycle_datapath #(.XLEN(32), .REG_NUM(32), .RESET_PC(RESET_PC)) dut (
    .iClk(iClk), .iRst_n(iRst_n),
    .oInst_Req(oInst_Req), .oInst_Addr(oInst_Addr), .iInst_Vld(iInst_Vld), .iInst_Code(iInst_Code),
    .oData_Req(oData_Req), .oData_We(oData_We), .oData_Addr(oData_Addr), .oData_WrData(oData_WrData),
    .iData_Ack(iData_Ack), .iData_RdData(iData_RdData),
    .iDbg_RegAddr(iDbg_RegAddr), .oDbg_RegData(oDbg_RegData), .oIllegal(oIllegal)
  );

  always #5 iClk = ~iClk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;
  bit dbg_rand = 1'b0;

  always @(posedge iClk) cyc <= cyc + 1;

  // architectural state: what the program has committed so far
  logic [31:0] m_regs [32];
  logic [31:0] m_pc, m_daddr, m_dwdata;
  logic        m_dwe, m_mem_exp, m_illegal;
  int          m_lat;

  int          last_lat, d_req_cycles;
  logic [31:0] d_addr, d_wdata;
  logic        d_we;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] m_reg(input logic [4:0] i);
    return (i == 5'd0) ? 32'h0 : m_regs[i];
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_pc = RESET_PC;
    m_mem_exp = 1'b0;
    m_illegal = 1'b0;
    m_dwe = 1'b0;
    m_daddr = 32'h0;
    m_dwdata = 32'h0;
  endtask

  task automatic model_apply(input logic [31:0] code, input logic [31:0] rdata);
    logic [31:0] a, b, ii, is;
    logic [4:0]  rd;
    logic [2:0]  f3;
    a  = m_reg(code[19:15]);
    b  = m_reg(code[24:20]);
    rd = code[11:7];
    f3 = code[14:12];
    ii = {{20{code[31]}}, code[31:20]};
    is = {{20{code[31]}}, code[31:25], code[11:7]};
    m_mem_exp = 1'b0;
    m_lat = -1;
    case (code[6:0])
      7'b0110011: begin
        if (rd != 0) m_regs[rd] = alu_ref(f3, code[30], a, b);
        m_lat = 4;
      end
      7'b0010011: begin
        if (rd != 0) m_regs[rd] = alu_ref(f3, (f3 == 3'd5) && code[30], a, ii);
        m_lat = 4;
      end
      7'b0000011: if (f3 == 3'd2) begin
        m_mem_exp = 1'b1; m_dwe = 1'b0; m_daddr = a + ii;
        if (rd != 0) m_regs[rd] = rdata;
        m_lat = 5;
      end
      7'b0100011: if (f3 == 3'd2) begin
        m_mem_exp = 1'b1; m_dwe = 1'b1; m_daddr = a + is; m_dwdata = b;
        m_lat = 4;
      end
      default: ;
    endcase
    m_pc = m_pc + 32'd4;
  endtask

  always @(negedge iClk) begin
    if (cmp_en) begin
      check("req_exclusive", {63'b0, oInst_Req & oData_Req}, 64'd0);
      check("illegal_flag", {63'b0, oIllegal}, {63'b0, m_illegal});
      check("unexpected_data_req", {63'b0, oData_Req & ~m_mem_exp}, 64'd0);
      if (oInst_Req) begin
        check("fetch_addr", {32'b0, oInst_Addr}, {32'b0, m_pc});
        check("dbg_read", {32'b0, oDbg_RegData}, {32'b0, m_reg(iDbg_RegAddr)});
      end
      if (oData_Req) begin
        check("data_addr", {32'b0, oData_Addr}, {32'b0, m_daddr});
        check("data_we", {63'b0, oData_We}, {63'b0, m_dwe});
        if (m_dwe) check("data_wdata", {32'b0, oData_WrData}, {32'b0, m_dwdata});
      end
    end
  end

  initial begin
    forever begin
      @(posedge iClk);
      #2;
      if (dbg_rand) iDbg_RegAddr = 5'($urandom);
    end
  end

  task automatic wait_fetch(output bit ok);
    int n;
    n = 0;
    while (!oInst_Req && n < 50) begin
      @(negedge iClk);
      n++;
    end
    ok = oInst_Req;
  endtask

  task automatic run_instr(input logic [31:0] code, input int fw, input int dw,
                           input logic [31:0] rdata);
    int start, n, dleft;
    bit ok;
    wait_fetch(ok);
    if (!ok) begin
      fail_now("fetch_request");
      return;
    end
    start = cyc;
    repeat (fw) @(negedge iClk);
    iInst_Vld = 1'b1;
    iInst_Code = code;
    @(posedge iClk);
    #1;
    model_apply(code, rdata);
    iInst_Vld = 1'b0;
    iInst_Code = $urandom;
    dleft = dw;
    n = 0;
    d_req_cycles = 0;
    forever begin
      @(negedge iClk);
      iData_Ack = 1'b0;
      iData_RdData = $urandom;
      if (oInst_Req) break;
      if (++n > 40) begin
        fail_now("instr_complete");
        break;
      end
      if (oData_Req) begin
        if (d_req_cycles == 0) begin
          d_addr = oData_Addr; d_wdata = oData_WrData; d_we = oData_We;
        end
        d_req_cycles++;
        if (dleft > 0) dleft--;
        else begin
          iData_Ack = 1'b1;
          iData_RdData = rdata;
        end
      end
    end
    last_lat = cyc - start;
    if (m_lat >= 0)
      check("latency", 64'(last_lat), 64'(m_lat + fw + (m_mem_exp ? dw : 0)));
  endtask

  task automatic dbg_check(input string name, input logic [4:0] idx, input logic [31:0] exp);
    iDbg_RegAddr = idx;
    #1;
    check(name, {32'b0, oDbg_RegData}, {32'b0, exp});
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [2:0]  f3;
    logic        alt;
    logic [11:0] imm;
    int          k;
    r   = $urandom;
    f3  = r[14:12];
    alt = r[30] && (f3 == 3'd0 || f3 == 3'd5);
    k   = $urandom_range(0, TRAP_BUILD ? 5 : 6);
    case (k)
      0, 1: return {1'b0, alt, 5'b0, r[24:15], f3, r[11:7], 7'b0110011};
      2, 3: begin
        imm = r[31:20];
        if (f3 == 3'd1) imm[11:5] = 7'b0;
        if (f3 == 3'd5) imm[11:5] = {1'b0, r[30], 5'b0};
        return {imm, r[19:15], f3, r[11:7], 7'b0010011};
      end
      4:       return {r[31:15], 3'b010, r[11:7], 7'b0000011};
      5:       return {r[31:15], 3'b010, r[11:7], 7'b0100011};
      default: return r[0] ? {r[31:7], 7'b1111111} : {r[31:15], 3'b000, r[11:7], 7'b0000011};
    endcase
  endfunction

  initial begin
    int n;
    bit ok;
    logic [31:0] pc_before;
    iInst_Vld = 1'b0; iInst_Code = 32'h0; iData_Ack = 1'b0; iData_RdData = 32'h0;
    iDbg_RegAddr = 5'd0;
    model_reset();

    repeat (3) @(negedge iClk);
    check("rst_data_req", {63'b0, oData_Req}, 64'd0);
    check("rst_data_we", {63'b0, oData_We}, 64'd0);
    check("rst_illegal", {63'b0, oIllegal}, 64'd0);
    check("rst_pc", {32'b0, oInst_Addr}, {32'b0, RESET_PC});
    iRst_n = 1'b1;
    #1;
    check("first_fetch_req", {63'b0, oInst_Req}, 64'd1);
    cmp_en = 1'b1;

    run_instr(32'h00500093, 0, 0, 32'h0);
    check("addi_latency", 64'(last_lat), 64'd4);
    check("second_fetch_pc", {32'b0, oInst_Addr}, 64'h4);
    run_instr(32'h00108133, 0, 0, 32'h0);
    check("add_latency", 64'(last_lat), 64'd4);
    dbg_check("x2_after_add", 5'd2, 32'd10);

    run_instr(32'h00202423, 0, 3, 32'h0);
    check("sw_addr", {32'b0, d_addr}, 64'd8);
    check("sw_wdata", {32'b0, d_wdata}, 64'd10);
    check("sw_we", {63'b0, d_we}, 64'd1);
    check("sw_req_cycles", 64'(d_req_cycles), 64'd4);
    check("sw_next_pc", {32'b0, oInst_Addr}, 64'd12);

    run_instr(32'h00802183, 0, 0, 32'hDEADBEEF);
    check("lw_latency", 64'(last_lat), 64'd5);
    dbg_check("x3_after_lw", 5'd3, 32'hDEADBEEF);

    run_instr(32'h00700013, 0, 0, 32'h0);
    dbg_check("x0_stays_zero", 5'd0, 32'h0);

    dbg_rand = 1'b1;
    for (int i = 0; i < 300; i++)
      run_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    dbg_rand = 1'b0;

    // abandon a load part-way through its data wait
    cmp_en = 1'b0;
    run_instr(32'h00802183, 0, 0, 32'h13579BDF);
    wait_fetch(ok);
    iInst_Vld = 1'b1;
    iInst_Code = 32'h00802183;
    @(posedge iClk);
    #1 iInst_Vld = 1'b0;
    n = 0;
    while (!oData_Req && n < 10) begin
      @(negedge iClk);
      n++;
    end
    check("mid_mem_reached", {63'b0, oData_Req}, 64'd1);
    @(negedge iClk);
    #2 iRst_n = 1'b0;
    #1;
    check("async_rst_data_req", {63'b0, oData_Req}, 64'd0);
    check("async_rst_data_we", {63'b0, oData_We}, 64'd0);
    check("async_rst_pc", {32'b0, oInst_Addr}, {32'b0, RESET_PC});
    for (int i = 0; i < 32; i++) dbg_check("async_rst_reg", 5'(i), 32'h0);
    model_reset();
    @(negedge iClk);
    iRst_n = 1'b1;
    #1;
    check("post_rst_fetch_req", {63'b0, oInst_Req}, 64'd1);
    cmp_en = 1'b1;

    run_instr(32'h12300093, 0, 0, 32'h0);
`ifdef MC_DP_TRAP_EN
    wait_fetch(ok);
    cmp_en = 1'b0;
    iInst_Vld = 1'b1;
    iInst_Code = 32'hFFFFFFFF;
    @(posedge iClk);
    #1 iInst_Vld = 1'b0;
    repeat (2) @(negedge iClk);
    for (int i = 0; i < 8; i++) begin
      check("trap_no_fetch", {63'b0, oInst_Req}, 64'd0);
      check("trap_no_data", {63'b0, oData_Req}, 64'd0);
      check("trap_illegal", {63'b0, oIllegal}, 64'd1);
      @(negedge iClk);
    end
    dbg_check("trap_x1_kept", 5'd1, 32'h123);
`else
    pc_before = m_pc;
    run_instr(32'hFFFFFFFF, 0, 0, 32'h0);
    check("illegal_nop_pc", {32'b0, oInst_Addr}, {32'b0, pc_before + 32'd4});
    check("illegal_flag_tied", {63'b0, oIllegal}, 64'd0);
    dbg_check("illegal_x1_kept", 5'd1, 32'h123);
`endif

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete (checks=%0d errors=%0d)", checks, errors);
    $fatal(1);
  end

endmodule
